// File: rtl/wallace_multiplier_pipe.sv
// Three-stage pipelined WIDTH x WIDTH Wallace multiplier (unsigned/signed per beat).
// Define WALLACE_MULT_ACC_EN to turn the output stage into a multiply-accumulator.
module wallace_multiplier_pipe #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int PW = 2 * WIDTH;

    function automatic int next_rows(input int unsigned n);
        return int'(2 * (n / 3) + n % 3);
    endfunction

    function automatic int rows_at(input int unsigned lvl);
        int unsigned n;
        n = WIDTH;
        for (int unsigned i = 0; i < lvl; i++) n = next_rows(n);
        return int'(n);
    endfunction

    function automatic int tree_levels();
        int unsigned n;
        int d;
        n = WIDTH;
        d = 0;
        while (n > 2) begin
            n = next_rows(n);
            d++;
        end
        return d;
    endfunction

    localparam int LEVELS = tree_levels();

    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    assign adv3      = !v3 | out_ready;
    assign adv2      = !v2 | adv3;
    assign adv1      = !v1 | adv2;
    assign in_ready  = adv1;
    assign out_valid = v3;

    // S1: partial products; the MSB row of a signed multiplicand carries negative weight
    logic [PW-1:0] b_ext;
    logic [PW-1:0] pp_d [WIDTH];
    logic [PW-1:0] pp_q [WIDTH];

    always_comb begin
        b_ext = signed_mode ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pp_d[i] = '0;
            if (a[i]) begin
                if (signed_mode && (i == WIDTH - 1)) pp_d[i] = '0 - (b_ext << i);
                else                                 pp_d[i] = b_ext << i;
            end
        end
    end

    // S2: 3:2 compressor tree, rows per level shrink as 2*(n/3) + n%3
    logic [PW-1:0] tree [LEVELS+1][WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lvl0
        assign tree[0][i] = pp_q[i];
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N = rows_at(l);
        localparam int G = N / 3;
        localparam int M = next_rows(N);
        for (genvar g = 0; g < G; g++) begin : g_csa
            logic [PW-1:0] x, y, z;
            assign x = tree[l][3*g];
            assign y = tree[l][3*g+1];
            assign z = tree[l][3*g+2];
            assign tree[l+1][2*g]   = x ^ y ^ z;
            assign tree[l+1][2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
        end
        for (genvar k = 0; k < N % 3; k++) begin : g_pass
            assign tree[l+1][2*G+k] = tree[l][3*G+k];
        end
        for (genvar k = M; k < WIDTH; k++) begin : g_pad
            assign tree[l+1][k] = '0;
        end
    end

    logic [PW-1:0] sum_q, carry_q, product;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1) v1 <= in_valid;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
        end
    end

    always_ff @(posedge clk) begin
        if (adv1) pp_q <= pp_d;
        if (adv2) begin
            sum_q   <= tree[LEVELS][0];
            carry_q <= tree[LEVELS][1];
        end
    end

    assign product = sum_q + carry_q;

`ifdef WALLACE_MULT_ACC_EN
    logic clr1, clr2;

    always_ff @(posedge clk) begin
        if (adv1) clr1 <= acc_clr;
        if (adv2) clr2 <= clr1;
    end

    // result doubles as the accumulator; it only moves when a valid beat enters S3
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             result <= '0;
        else if (adv3 && v2) result <= (clr2 ? '0 : result) + product;
    end
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             result <= '0;
        else if (adv3 && v2) result <= product;
    end
`endif

endmodule
